// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - select/data sequencer that serializes an 8-bit word through an 8:1 bit mux
module mux_scan_sequencer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [7:0] word_out,
    output logic [2:0] sel,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       bit_last,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic [2:0] cnt_nx;
    logic [7:0] word_nx;
    logic       frame_done_nx;
    logic       accept;
    logic       load_fire;

    // Handshake qualifiers; sel and bit_last come only from registered state
    assign bit_valid  = (state == SHIFT);
    assign busy       = bit_valid;
    assign bit_last   = bit_valid & (cnt == 3'd7);
    assign accept     = bit_valid & bit_ready;
    assign load_ready = ~abort & (~bit_valid | (accept & bit_last));
    assign load_fire  = load_valid & load_ready;
    assign sel        = MSB_FIRST ? (3'd7 - cnt) : cnt;

    // State register: reset wins over abort, load and accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            word_out   <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            word_out   <= word_nx;
            frame_done <= frame_done_nx;
        end
    end

    // Next state: abort cancels silently; a load on the final accept chains the next word
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        word_nx       = word_out;
        frame_done_nx = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            cnt_nx   = 3'd0;
        end else begin
            if (accept) begin
                if (bit_last) begin
                    state_nx      = IDLE;
                    cnt_nx        = 3'd0;
                    frame_done_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            if (load_fire) begin
                word_nx  = load_data;
                cnt_nx   = 3'd0;
                state_nx = SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer in both bit orders
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic       load_valid;
    logic [7:0] load_data;
    logic       bit_ready;

    logic       lr0, lr1, bv0, bv1, bl0, bl1, by0, by1, fd0, fd1;
    logic [7:0] wo0, wo1;
    logic [2:0] sel0, sel1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_sequencer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .load_valid(load_valid), .load_data(load_data), .load_ready(lr0),
        .word_out(wo0), .sel(sel0), .bit_valid(bv0), .bit_ready(bit_ready),
        .bit_last(bl0), .busy(by0), .frame_done(fd0)
    );

    mux_scan_sequencer #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .load_valid(load_valid), .load_data(load_data), .load_ready(lr1),
        .word_out(wo1), .sel(sel1), .bit_valid(bv1), .bit_ready(bit_ready),
        .bit_last(bl1), .busy(by1), .frame_done(fd1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: one entry per expected bit, holding the expected sel for each DUT
    int         q0[$];
    int         q1[$];
    logic [7:0] m_word = 8'h00;
    logic       fd_exp = 1'b0;
    int         acc_cnt = 0;
    int         fd_cnt = 0;
    logic       m_busy, m_last, acc, lr_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_word = 8'h00;
            fd_exp = 1'b0;
        end else begin
            m_busy = (q0.size() != 0);
            m_last = (q0.size() == 1);
            acc    = m_busy && bit_ready;
            lr_exp = !abort && (!m_busy || (acc && m_last));
            check("valid0", 32'(bv0), 32'(m_busy));
            check("valid1", 32'(bv1), 32'(m_busy));
            check("busy0", 32'(by0), 32'(m_busy));
            check("last0", 32'(bl0), 32'(m_busy && m_last));
            check("last1", 32'(bl1), 32'(m_busy && m_last));
            check("ready0", 32'(lr0), 32'(lr_exp));
            check("ready1", 32'(lr1), 32'(lr_exp));
            check("fdone0", 32'(fd0), 32'(fd_exp));
            check("fdone1", 32'(fd1), 32'(fd_exp));
            check("word0", 32'(wo0), 32'(m_word));
            check("word1", 32'(wo1), 32'(m_word));
            if (m_busy) begin
                check("sel0", 32'(sel0), 32'(q0[0]));
                check("sel1", 32'(sel1), 32'(q1[0]));
            end else begin
                check("sel_idle0", 32'(sel0), 32'd0);
                check("sel_idle1", 32'(sel1), 32'd7);
            end
            if (acc) begin
                check("y0", 32'(wo0[sel0]), 32'(m_word[q0[0]]));
                check("y1", 32'(wo1[sel1]), 32'(m_word[q1[0]]));
                acc_cnt++;
            end
            if (fd0) fd_cnt++;
            if (abort) begin
                q0.delete();
                q1.delete();
                fd_exp = 1'b0;
            end else begin
                fd_exp = acc && m_last;
                if (acc) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
                if (load_valid && lr_exp) begin
                    for (int i = 0; i < 8; i++) begin
                        q0.push_back(i);
                        q1.push_back(7 - i);
                    end
                    m_word = load_data;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and return once it has been taken, reporting how many cycles it waited
    task automatic load_word(input logic [7:0] d, output int waits);
        logic got;
        load_valid = 1'b1;
        load_data  = d;
        waits      = 0;
        forever begin
            @(negedge clk);
            got = lr0;
            tick();
            if (got) break;
            waits++;
            if (waits > 40) begin
                check("load_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        load_valid = 1'b0;
    endtask

    // Drain the current word; mode 1 applies the 1,0,0 bit_ready pattern
    task automatic run_idle(input int mode, output int cyc);
        int k;
        cyc = 0;
        k   = 0;
        forever begin
            bit_ready = (mode == 1) ? (k % 3 == 0) : 1'b1;
            @(negedge clk);
            if (!bv0) break;
            cyc++;
            k++;
            tick();
            if (cyc > 200) begin
                check("drain_timeout", 32'(cyc), 32'd0);
                break;
            end
        end
        bit_ready = 1'b1;
        tick();
    endtask

    int w, c, a0, f0;

    initial begin
        rst_n      = 1'b0;
        abort      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        bit_ready  = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_word", 32'(wo0), 32'h00);
        check("rst_sel0", 32'(sel0), 32'd0);
        check("rst_sel1", 32'(sel1), 32'd7);
        check("rst_valid", 32'(bv0), 32'd0);
        check("rst_busy", 32'(by0), 32'd0);
        check("rst_fdone", 32'(fd0), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        a0 = acc_cnt; f0 = fd_cnt;
        load_word(8'hA5, w);
        run_idle(0, c);
        check("a5_cycles", 32'(c), 32'd8);
        check("a5_bits", 32'(acc_cnt - a0), 32'd8);
        check("a5_fdone", 32'(fd_cnt - f0), 32'd1);

        a0 = acc_cnt; f0 = fd_cnt;
        load_word(8'hFF, w);
        load_word(8'h00, w);
        check("b2b_wait", 32'(w), 32'd7);
        run_idle(0, c);
        check("b2b_tail", 32'(c), 32'd8);
        check("b2b_bits", 32'(acc_cnt - a0), 32'd16);
        check("b2b_fdone", 32'(fd_cnt - f0), 32'd2);

        a0 = acc_cnt; f0 = fd_cnt;
        load_word(8'h3C, w);
        run_idle(1, c);
        check("bp_cycles", 32'(c), 32'd22);
        check("bp_bits", 32'(acc_cnt - a0), 32'd8);
        check("bp_fdone", 32'(fd_cnt - f0), 32'd1);

        a0 = acc_cnt;
        load_word(8'h01, w);
        run_idle(0, c);
        check("msb_bits", 32'(acc_cnt - a0), 32'd8);

        f0 = fd_cnt;
        load_word(8'hC3, w);
        repeat (3) tick();
        abort = 1'b1;
        @(negedge clk);
        check("abort_lr", 32'(lr0), 32'd0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(bv0), 32'd0);
        check("abort_fdone", 32'(fd0), 32'd0);
        check("abort_lr_after", 32'(lr0), 32'd1);
        tick();
        check("abort_no_fd", 32'(fd_cnt - f0), 32'd0);

        load_word(8'h81, w);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_word", 32'(wo0), 32'h00);
        check("mid_rst_sel", 32'(sel0), 32'd0);
        check("mid_rst_valid", 32'(bv0), 32'd0);
        tick();
        a0 = acc_cnt;
        load_word(8'h81, w);
        run_idle(0, c);
        check("post_rst_bits", 32'(acc_cnt - a0), 32'd8);

        a0 = acc_cnt;
        load_word(8'hF0, w);
        repeat (2) tick();
        load_valid = 1'b1;
        load_data  = 8'h55;
        @(negedge clk);
        check("busy_lr", 32'(lr0), 32'd0);
        tick();
        load_valid = 1'b0;
        run_idle(0, c);
        check("f0_bits", 32'(acc_cnt - a0), 32'd8);
        check("f0_word", 32'(wo0), 32'hF0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream select/data sequencer for the 8:1 bit multiplexer (mux8to1).
- Accepts an 8-bit word through a valid/ready handshake and holds it on word_out, which drives the mux D inputs.
- Steps sel through all 8 positions, one position per accepted beat, so the mux output Y becomes a serial bitstream.
- Tells the downstream consumer when each serial bit is valid and which bit is last in the word.

Parameters:
- MSB_FIRST, default 0: 0 gives sel order 0,1,...,7; 1 gives sel order 7,6,...,0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- abort  input  1  synchronous cancel of the word currently being sent.
- load_valid  input  1  upstream has a word ready on load_data.
- load_data  input  8  word to serialize.
- load_ready  output  1  sequencer accepts load_data this cycle.
- word_out  output  8  held word; connects to mux D.
- sel  output  3  mux select.
- bit_valid  output  1  mux Y is a valid serial bit this cycle.
- bit_ready  input  1  downstream accepts the current bit.
- bit_last  output  1  current bit is the 8th bit of the word.
- busy  output  1  a word is in flight.
- frame_done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- States:
  - IDLE: no word held; waiting for a load.
  - SHIFT: a word is held and its bits are being presented.
- Internal 3-bit beat counter cnt, range 0..7.
  - sel = cnt when MSB_FIRST=0.
  - sel = 7-cnt when MSB_FIRST=1.
  - Both are registered-state derived, with no combinational path from inputs.
- Reset (rst_n=0 at a clock edge) forces:
  - state=IDLE, cnt=0, word_out=8'h00;
  - bit_valid=0, busy=0, frame_done=0;
  - sel=0 (MSB_FIRST=0) or 7 (MSB_FIRST=1).
- Reset takes priority over every other input, including when it arrives mid-word.
- Definitions:
  - bit_valid = (state==SHIFT).
  - busy = bit_valid.
  - bit_last = bit_valid & (cnt==7).
  - accept = bit_valid & bit_ready.
- load_ready (combinational) = (state==IDLE) | (accept & bit_last). This allows back-to-back words with no bubble.
- Load transfer (load_valid & load_ready):
  - word_out <= load_data, cnt <= 0, state <= SHIFT.
  - The first bit is valid in the following cycle, giving 1-cycle latency from load to first bit.
- accept with cnt<7: cnt <= cnt+1.
- accept with cnt==7 and no load: state <= IDLE, cnt <= 0.
  - word_out keeps its last value.
  - frame_done=1 in the next cycle only.
- accept with cnt==7 and a simultaneous load:
  - New word loads, cnt <= 0, state stays SHIFT.
  - frame_done still pulses for the completed word.
- bit_ready=0 while bit_valid=1: sel, word_out and cnt all hold. The stall may be unbounded.
- load_valid while SHIFT and not on the last accept: ignored (load_ready=0). Upstream must hold its word.
- abort=1 (not in reset):
  - Next cycle: state=IDLE, cnt=0, no frame_done pulse; word_out holds its value.
  - abort has priority over load and accept in the same cycle, so load_ready is forced to 0 while abort=1.
- Throughput: 8 cycles per word when bit_ready is held high.
- A word is therefore accepted at most once every 8 cycles.

Test Plan:
- Reset then basic word:
  - Stimulus: after rst_n=0 for 2 cycles, check all outputs are at reset values; then load 8'hA5 with bit_ready=1 and MSB_FIRST=0.
  - Required: sel runs 0..7 over 8 consecutive cycles and the mux Y sequence is 1,0,1,0,0,1,0,1.
  - Required: bit_last is high only at sel=7, and frame_done pulses once on the next cycle.
- Back-to-back words:
  - Stimulus: load_valid held high with 8'hFF, then 8'h00.
  - Required: load_ready=1 on the last beat; 16 consecutive valid bits (eight 1s, then eight 0s) with no idle cycle; two frame_done pulses.
- Backpressure:
  - Stimulus: word 8'h3C, bit_ready toggled 1,0,0,1,...
  - Required: sel and word_out are frozen on the stall cycles; Y sequence equals 0,0,1,1,1,1,0,0; total bits transferred = 8.
- MSB_FIRST=1:
  - Stimulus: word 8'h01.
  - Required: sel runs 7..0 and Y sequence is 0,0,0,0,0,0,0,1.
- Abort and mid-word reset:
  - Stimulus: abort at cnt=3 of 8'hC3; then load 8'h81 and assert rst_n=0 at cnt=5.
  - Required: after abort, next cycle is IDLE with no frame_done and load_ready=1.
  - Required: after reset, word_out=8'h00, sel=0, bit_valid=0, and a subsequent load serializes correctly.
- Load ignored while busy:
  - Stimulus: pulse load_valid with 8'h55 at cnt=2 of word 8'hF0.
  - Required: load_ready=0 at that cycle and the F0 bit sequence is unaffected.
